// File: rtl/fsm_1110_framer_tx_if.sv
// Source-side handshake plus serial line of the 1110 framer transmitter.
interface fsm_1110_framer_tx_if #(
   parameter int unsigned DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              out_bit;
   logic              out_en;
   logic              frame_done;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  out_bit,
      input  out_en,
      input  frame_done
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output out_bit,
      output out_en,
      output frame_done
   );
endinterface

// File: rtl/fsm_1110_framer_tx.sv
// Serial framer: preamble 1110, then bit-stuffed MSB-first payload so "111" never
// occurs inside a frame, then GAP_W idle zeros.
module fsm_1110_framer_tx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned GAP_W  = 2
) (
   input  logic                clk,
   input  logic                reset,
   fsm_1110_framer_tx_if.slave tx_if
);

   localparam int unsigned IDX_W = $clog2(DATA_W);
   localparam int unsigned CNT_W = (GAP_W > 4) ? $clog2(GAP_W) : 2;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] PreLast = CNT_W'(3);
   localparam logic [CNT_W-1:0] GapLast = CNT_W'(GAP_W - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPre,
      StData,
      StStuff,
      StGap
   } state_e;

   state_e            r_state;
   logic [DATA_W-1:0] r_shift;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [1:0]        r_ones;
   logic              r_out_bit;
   logic              r_out_en;
   logic              r_frame_done;

   state_e            w_state;
   logic [DATA_W-1:0] w_shift;
   logic [CNT_W-1:0]  w_cnt;
   logic [IDX_W-1:0]  w_idx;
   logic [1:0]        w_ones;
   logic              w_out_bit;
   logic              w_out_en;
   logic              w_frame_done;
   logic              w_emit;

   // Registered outputs always describe the bit currently on the line, so the
   // next-state logic computes the bit for the following cycle.
   always_comb begin
      w_state      = r_state;
      w_shift      = r_shift;
      w_cnt        = r_cnt;
      w_idx        = r_idx;
      w_ones       = r_ones;
      w_out_bit    = 1'b0;
      w_out_en     = 1'b0;
      w_frame_done = 1'b0;
      w_emit       = 1'b0;

      case (r_state)
         StIdle: begin
            if (tx_if.tx_valid) begin
               w_state   = StPre;
               w_shift   = tx_if.tx_data;
               w_cnt     = '0;
               w_ones    = 2'd0;
               w_out_bit = 1'b1;
               w_out_en  = 1'b1;
            end
         end
         StPre: begin
            if (r_cnt == PreLast) begin
               w_state = StData;
               w_idx   = '0;
               w_emit  = 1'b1;
            end else begin
               w_cnt     = r_cnt + CNT_W'(1);
               w_out_bit = (r_cnt != CNT_W'(2));
               w_out_en  = 1'b1;
            end
         end
         StData: begin
            if (r_idx == LastIdx) begin
               w_state = StGap;
               w_cnt   = '0;
               w_ones  = 2'd0;
            end else if (r_ones == 2'd2) begin
               w_state  = StStuff;
               w_ones   = 2'd0;
               w_out_en = 1'b1;
            end else begin
               w_idx  = r_idx + IDX_W'(1);
               w_emit = 1'b1;
            end
         end
         StStuff: begin
            w_state = StData;
            w_idx   = r_idx + IDX_W'(1);
            w_emit  = 1'b1;
         end
         StGap: begin
            if (r_cnt == GapLast) begin
               w_state = StIdle;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state = StIdle;
         end
      endcase

      if (w_emit) begin
         w_out_bit    = r_shift[DATA_W-1];
         w_out_en     = 1'b1;
         w_shift      = {r_shift[DATA_W-2:0], 1'b0};
         w_ones       = r_shift[DATA_W-1] ? (r_ones + 2'd1) : 2'd0;
         w_frame_done = (w_idx == LastIdx);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= StIdle;
         r_shift      <= '0;
         r_cnt        <= '0;
         r_idx        <= '0;
         r_ones       <= 2'd0;
         r_out_bit    <= 1'b0;
         r_out_en     <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_shift      <= w_shift;
         r_cnt        <= w_cnt;
         r_idx        <= w_idx;
         r_ones       <= w_ones;
         r_out_bit    <= w_out_bit;
         r_out_en     <= w_out_en;
         r_frame_done <= w_frame_done;
      end
   end

   assign tx_if.tx_ready   = (r_state == StIdle);
   assign tx_if.out_bit    = r_out_bit;
   assign tx_if.out_en     = r_out_en;
   assign tx_if.frame_done = r_frame_done;

endmodule

// File: tb/tb_fsm_1110_framer_tx.sv
// Bench for fsm_1110_framer_tx: directed frames plus random traffic, checked against
// a queue of expected line symbols built from the framing rules.
module tb_fsm_1110_framer_tx;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned GAP_W  = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fsm_1110_framer_tx_if #(.DATA_W(DATA_W)) tx_if ();

   fsm_1110_framer_tx #(
      .DATA_W(DATA_W),
      .GAP_W (GAP_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .tx_if(tx_if)
   );

   int checks   = 0;
   int failures = 0;

   // Expected line symbols {frame_done, out_en, out_bit}; head is the current cycle.
   logic [2:0] exp_q[$];

   int         hs_cnt;
   int         cyc;
   int         last_done_cyc;
   int         det_cnt;
   logic [3:0] hist;
   bit         det_on;
   bit         b2b_on;
   logic       prev_en;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_frame(input logic [DATA_W-1:0] w);
      int run;
      run = 0;
      exp_q.push_back(3'b011);
      exp_q.push_back(3'b011);
      exp_q.push_back(3'b011);
      exp_q.push_back(3'b010);
      for (int i = DATA_W - 1; i >= 0; i--) begin
         exp_q.push_back({(i == 0), 1'b1, w[i]});
         run = w[i] ? run + 1 : 0;
         if (run == 2 && i > 0) begin
            exp_q.push_back(3'b010);
            run = 0;
         end
      end
      for (int g = 0; g < int'(GAP_W); g++) exp_q.push_back(3'b000);
   endtask

   task automatic step(input logic rst_n, input logic v, input logic [DATA_W-1:0] d);
      logic       ready_now;
      logic [2:0] e;
      reset          = rst_n;
      tx_if.tx_valid = v;
      tx_if.tx_data  = d;
      @(posedge clk);
      ready_now = (exp_q.size() == 0);
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (v && ready_now) begin
            push_frame(d);
            hs_cnt++;
         end
      end
      #1;
      cyc++;
      e = (exp_q.size() > 0) ? exp_q[0] : 3'b000;
      check_eq("out_bit", 32'(tx_if.out_bit), 32'(e[0]));
      check_eq("out_en", 32'(tx_if.out_en), 32'(e[1]));
      check_eq("frame_done", 32'(tx_if.frame_done), 32'(e[2]));
      check_eq("tx_ready", 32'(tx_if.tx_ready), 32'(exp_q.size() == 0));
      if (det_on) begin
         hist = {hist[2:0], tx_if.out_bit};
         if (hist == 4'b1110) det_cnt++;
      end
      if (b2b_on && tx_if.out_en && !prev_en && last_done_cyc >= 0)
         check_eq("b2b_spacing", 32'(cyc - last_done_cyc), 32'(GAP_W + 2));
      if (tx_if.frame_done) last_done_cyc = cyc;
      prev_en = tx_if.out_en;
      @(negedge clk);
   endtask

   initial begin
      int hs_base;
      int target;
      reset          = 1'b0;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = '0;
      hs_cnt         = 0;
      cyc            = 0;
      last_done_cyc  = -1;
      det_cnt        = 0;
      hist           = 4'b0000;
      det_on         = 1'b0;
      b2b_on         = 1'b0;
      prev_en        = 1'b0;
      @(negedge clk);

      // Reset held, with tx_valid asserted to show it is not latched.
      repeat (3) step(1'b0, 1'b1, 8'h5A);
      repeat (2) step(1'b1, 1'b0, 8'h5A);

      det_on  = 1'b1;
      hs_base = hs_cnt;
      step(1'b1, 1'b1, 8'h00);
      repeat (16) step(1'b1, 1'b0, 8'hFF);
      step(1'b1, 1'b1, 8'hFF);
      repeat (18) step(1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'hB6);
      repeat (18) step(1'b1, 1'b0, 8'h00);

      // Back-to-back: valid held high, data changes while the first frame is on the line.
      last_done_cyc = -1;
      b2b_on        = 1'b1;
      target        = hs_cnt + 2;
      step(1'b1, 1'b1, 8'hFF);
      for (int i = 0; i < 40; i++) step(1'b1, (hs_cnt < target), 8'h00);
      b2b_on = 1'b0;
      det_on = 1'b0;
      check_eq("hs_b2b", 32'(hs_cnt), 32'(target));
      check_eq("det_per_frame", 32'(det_cnt), 32'(hs_cnt - hs_base));

      // Abort during payload bit 3, then a fresh frame.
      step(1'b1, 1'b1, 8'hA5);
      repeat (6) step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h3C);
      repeat (20) step(1'b1, 1'b0, 8'h00);

      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
              DATA_W'($urandom));
      end
      repeat (20) step(1'b1, 1'b0, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
